mmio_bridge: RTL

Memory-mapped I/O bridge between the CPU data port A and the EXRAM / board I/O. It decodes CPU addresses at and above IO_MEM and gates RAM write-enable for that range. It owns a registered 16-bit seven-segment display latch and a synchronized, debounced switch register. It aligns I/O read data with the EXRAM one-cycle synchronous read latency, so the CPU sees a uniform 1-cycle read for every address.

---
 rtl/cpu_mem_map_pkg.sv | 26 ++
 rtl/switch_debounce.sv | 68 ++++++
 rtl/mmio_bridge.sv | 104 ++++++++++
 3 files changed

// File: rtl/cpu_mem_map_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mem_map_pkg
// Description : CPU memory map constants and the read-select encoding shared
//               by the MMIO bridge and its neighbours.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_mem_map_pkg;

    localparam logic [15:0] INSTRUCTION_MEM   = 16'h0000;
    localparam logic [15:0] DATA_STACK        = 16'hCFFC;
    localparam logic [15:0] IO_MEM            = 16'hCFFD;
    localparam logic [15:0] SWITCHES_LOC      = 16'hCFFD;
    localparam logic [15:0] LEDS_LOC          = 16'hCFFE;
    localparam logic [15:0] INTERRUPT_CONTROL = 16'hD000;

    // Source of the read data presented to the CPU one cycle after the address
    typedef enum logic [1:0] {
        RAM  = 2'd0,
        SW   = 2'd1,
        LEDS = 2'd2,
        NONE = 2'd3
    } rd_sel_e;

endpackage
`default_nettype wire

// File: rtl/switch_debounce.sv
`default_nettype none
// ============================================================================
// Module      : switch_debounce
// Description : Two-flop synchronizer plus whole-vector debouncer for board
//               switches; pulses sw_event for one cycle on every accepted
//               change of sw_stable.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_debounce #(
    parameter int SW_WIDTH        = 8,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SW_WIDTH-1:0] switches,
    output logic [SW_WIDTH-1:0] sw_stable,
    output logic                sw_event
);

    // Counter never exceeds DEBOUNCE_CYCLES-1, so this width cannot wrap
    localparam int c_cnt_w = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic [SW_WIDTH-1:0] r_sync1;
    logic [SW_WIDTH-1:0] r_sync2;
    logic [SW_WIDTH-1:0] r_sync_q;
    logic [SW_WIDTH-1:0] r_stable;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_event;

    // Bring the asynchronous switches into the clock domain and keep one cycle of history
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_sync_q <= '0;
        end else begin
            r_sync1  <= switches;
            r_sync2  <= r_sync1;
            r_sync_q <= r_sync2;
        end
    end

    // Accept a new vector only after it has been steady and different for the full window
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_stable <= '0;
            r_event  <= 1'b0;
        end else begin
            r_event <= 1'b0;
            if ((r_sync2 != r_sync_q) || (r_sync2 == r_stable)) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
                r_event  <= 1'b1;
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end
    end

    assign sw_stable = r_stable;
    assign sw_event  = r_event;

endmodule
`default_nettype wire

// File: rtl/mmio_bridge.sv
`default_nettype none
// ============================================================================
// Module      : mmio_bridge
// Description : CPU data-port bridge to EXRAM and board I/O. Blocks RAM writes
//               in the I/O range, owns the seven-segment display latch and
//               the debounced switch register, and returns every read with a
//               uniform one-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_bridge #(
    parameter int               WIDTH           = 16,
    parameter logic [WIDTH-1:0] IO_MEM          = cpu_mem_map_pkg::IO_MEM,
    parameter logic [WIDTH-1:0] SWITCHES_LOC    = cpu_mem_map_pkg::SWITCHES_LOC,
    parameter logic [WIDTH-1:0] LEDS_LOC        = cpu_mem_map_pkg::LEDS_LOC,
    parameter int               SW_WIDTH        = 8,
    parameter int               DEBOUNCE_CYCLES = 500000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WIDTH-1:0]    cpu_addr,
    input  logic [WIDTH-1:0]    cpu_wdata,
    input  logic                cpu_wren,
    output logic [WIDTH-1:0]    cpu_rdata,
    output logic                ram_wren,
    input  logic [WIDTH-1:0]    ram_q,
    input  logic [SW_WIDTH-1:0] switches,
    output logic [WIDTH-1:0]    seg_code,
    output logic                sw_event
);

    import cpu_mem_map_pkg::*;

    logic                w_io;
    rd_sel_e             w_rd_sel_next;
    rd_sel_e             r_rd_sel;
    logic [WIDTH-1:0]    r_seg_code;
    logic [SW_WIDTH-1:0] w_sw_stable;
    logic [WIDTH-1:0]    w_sw_ext;

    assign w_io     = (cpu_addr >= IO_MEM);
    assign ram_wren = cpu_wren && !w_io;

    // Display latch: only LEDS_LOC writes land; every other I/O write is dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seg_code <= '0;
        end else if (cpu_wren && (cpu_addr == LEDS_LOC)) begin
            r_seg_code <= cpu_wdata;
        end
    end

    assign seg_code = r_seg_code;

    // Classify the current address so the data can be picked next cycle
    always_comb begin
        w_rd_sel_next = NONE;
        if (!w_io) begin
            w_rd_sel_next = RAM;
        end else if (cpu_addr == SWITCHES_LOC) begin
            w_rd_sel_next = SW;
        end else if (cpu_addr == LEDS_LOC) begin
            w_rd_sel_next = LEDS;
        end
    end

    // Delay the selection by one cycle to line up with the EXRAM read latency
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_sel <= NONE;
        end else begin
            r_rd_sel <= w_rd_sel_next;
        end
    end

    // Zero-extend the switch vector to the bus width
    always_comb begin
        w_sw_ext                 = '0;
        w_sw_ext[SW_WIDTH-1:0]   = w_sw_stable;
    end

    // Read data mux; LEDS returns the live latch so a write is visible immediately
    always_comb begin
        cpu_rdata = '0;
        case (r_rd_sel)
            RAM:     cpu_rdata = ram_q;
            SW:      cpu_rdata = w_sw_ext;
            LEDS:    cpu_rdata = r_seg_code;
            default: cpu_rdata = '0;
        endcase
    end

    switch_debounce #(
        .SW_WIDTH        (SW_WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_switch_debounce (
        .clk       (clk),
        .reset     (reset),
        .switches  (switches),
        .sw_stable (w_sw_stable),
        .sw_event  (sw_event)
    );

endmodule
`default_nettype wire
